// File: rtl/clk_period_meter_if.sv
// Bundle between the period meter and whatever consumes its measurements.
// The meter sits on the master side and drives every field except sig_in.
interface clk_period_meter_if #(
    parameter int unsigned CNT_W = 16
);
    logic             sig_in;
    logic             meas_valid;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             locked;
    logic             stalled;

    modport master (
        input  sig_in,
        output meas_valid,
        output period,
        output high_time,
        output locked,
        output stalled
    );

    modport slave (
        output sig_in,
        input  meas_valid,
        input  period,
        input  high_time,
        input  locked,
        input  stalled
    );
endinterface

// File: rtl/clk_period_meter.sv
// Measures the period and high time of a slow strobe in system clock cycles,
// with lock detection on repeated identical measurements and stall detection.
module clk_period_meter #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned LOCK_CNT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    clk_period_meter_if.master bus
);
    localparam int unsigned       MatchW   = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0]  CntMax   = '1;
    localparam logic [CNT_W-1:0]  CntOne   = CNT_W'(1);
    localparam logic [MatchW-1:0] MatchMax = MatchW'(LOCK_CNT);

    typedef enum logic [1:0] {StIdle, StMeasHigh, StMeasLow} state_e;

    state_e            state_q, state_d;
    logic              s1_q, s2_q, s3_q;
    logic [CNT_W-1:0]  p_cnt_q, p_cnt_d;
    logic [CNT_W-1:0]  h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [CNT_W-1:0]  high_q, high_d;
    logic [MatchW-1:0] match_q, match_d;
    logic              valid_q, valid_d;
    logic              locked_q, locked_d;
    logic              stalled_q, stalled_d;
    logic              rise, fall, same;

    assign rise = s2_q & ~s3_q;
    assign fall = ~s2_q & s3_q;
    assign same = (p_cnt_q == period_q) && (h_cnt_q == high_q);

    always_comb begin
        state_d   = state_q;
        p_cnt_d   = p_cnt_q;
        h_cnt_d   = h_cnt_q;
        period_d  = period_q;
        high_d    = high_q;
        match_d   = match_q;
        valid_d   = 1'b0;
        locked_d  = locked_q;
        stalled_d = stalled_q;
        unique case (state_q)
            StIdle: begin
                p_cnt_d = '0;
                h_cnt_d = '0;
                if (rise) begin
                    state_d   = StMeasHigh;
                    p_cnt_d   = CntOne;
                    h_cnt_d   = CntOne;
                    stalled_d = 1'b0;
                end
            end
            StMeasHigh: begin
                if (p_cnt_q == CntMax) begin
                    state_d   = StIdle;
                    p_cnt_d   = '0;
                    h_cnt_d   = '0;
                    stalled_d = 1'b1;
                    locked_d  = 1'b0;
                    match_d   = '0;
                end else begin
                    p_cnt_d = p_cnt_q + 1'b1;
                    // High time stops counting on the cycle the fall is seen.
                    if (fall) begin
                        state_d = StMeasLow;
                    end else begin
                        h_cnt_d = h_cnt_q + 1'b1;
                    end
                end
            end
            StMeasLow: begin
                if (rise) begin
                    state_d  = StMeasHigh;
                    valid_d  = 1'b1;
                    period_d = p_cnt_q;
                    high_d   = h_cnt_q;
                    p_cnt_d  = CntOne;
                    h_cnt_d  = CntOne;
                    if (!same) begin
                        match_d = MatchW'(1);
                    end else if (match_q != MatchMax) begin
                        match_d = match_q + 1'b1;
                    end
                    locked_d = (match_d == MatchMax);
                end else if (p_cnt_q == CntMax) begin
                    state_d   = StIdle;
                    p_cnt_d   = '0;
                    h_cnt_d   = '0;
                    stalled_d = 1'b1;
                    locked_d  = 1'b0;
                    match_d   = '0;
                end else begin
                    p_cnt_d = p_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
            p_cnt_q   <= '0;
            h_cnt_q   <= '0;
            period_q  <= '0;
            high_q    <= '0;
            match_q   <= '0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            stalled_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            s1_q      <= bus.sig_in;
            s2_q      <= s1_q;
            s3_q      <= s2_q;
            p_cnt_q   <= p_cnt_d;
            h_cnt_q   <= h_cnt_d;
            period_q  <= period_d;
            high_q    <= high_d;
            match_q   <= match_d;
            valid_q   <= valid_d;
            locked_q  <= locked_d;
            stalled_q <= stalled_d;
        end
    end

    assign bus.meas_valid = valid_q;
    assign bus.period     = period_q;
    assign bus.high_time  = high_q;
    assign bus.locked     = locked_q;
    assign bus.stalled    = stalled_q;
endmodule
